muldiv_seq: RTL and testbench

Iterative 16-bit unsigned multiply/divide/modulo unit: the responder side of the control unit's `ready` handshake. It watches `opsel`, and for `ALU_MUL`, `ALU_DIV` and `ALU_MOD` it runs a multi-cycle shift-add or restoring-divide sequence. It holds `ready` low until the result is stable, then drives the ACC result, the X extra result (consumed via `extra_write_X`) and the four flags. For every other `opsel` code it answers `ready` immediately, so single-cycle ALU ops are never stalled.

---
 rtl/muldiv_seq_pkg.sv | 54 +++++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_seq.sv | 107 ++++++++++
 tb/tb_muldiv_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared opcodes, FSM states, flag positions and result packing for the
// iterative multiply/divide unit.
package muldiv_seq_pkg;

  localparam int MD_W  = 16;
  localparam int CNT_W = 5;

  localparam logic [4:0] ALU_ADD = 5'h00;
  localparam logic [4:0] ALU_MUL = 5'h0C;
  localparam logic [4:0] ALU_DIV = 5'h0D;
  localparam logic [4:0] ALU_MOD = 5'h0E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_ZF = 3;
  localparam int FLAG_NF = 2;
  localparam int FLAG_CF = 1;
  localparam int FLAG_OF = 0;

  typedef struct packed {
    logic [MD_W-1:0] res;
    logic [MD_W-1:0] res_x;
    logic [3:0]      flags;
  } result_t;

  function automatic logic is_iter(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

  // lo/hi are P[15:0]/P[31:16] for MUL and Q/R for DIV/MOD.
  function automatic result_t pack_result(input logic is_mul, input logic is_mod,
                                          input logic [MD_W-1:0] lo,
                                          input logic [MD_W-1:0] hi,
                                          input logic dz);
    result_t r;
    r.res   = is_mod ? hi : lo;
    r.res_x = is_mod ? lo : hi;
    r.flags = '0;
    r.flags[FLAG_ZF] = (r.res == '0);
    r.flags[FLAG_NF] = r.res[MD_W-1];
    if (is_mul) begin
      r.flags[FLAG_CF] = (hi != '0);
      r.flags[FLAG_OF] = (hi != '0);
    end else begin
      r.flags[FLAG_OF] = dz;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of LSB-first shift-add multiply or restoring divide.
// DIV reuses sa[15:0] as dividend-in / quotient-out and acc[16:0] as remainder.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic        is_mul,
  input  logic [31:0] acc,
  input  logic [31:0] sa,
  input  logic [15:0] sb,
  output logic [31:0] acc_n,
  output logic [31:0] sa_n,
  output logic [15:0] sb_n,
  output logic        qbit
);

  logic [16:0] rem_sh;
  logic [17:0] trial;

  always_comb begin
    acc_n  = acc;
    sa_n   = sa;
    sb_n   = sb;
    qbit   = 1'b0;
    rem_sh = '0;
    trial  = '0;
    if (is_mul) begin
      if (sb[0]) acc_n = acc + sa;
      sa_n = sa << 1;
      sb_n = sb >> 1;
    end else begin
      rem_sh = {acc[15:0], sa[15]};
      trial  = {1'b0, rem_sh} - {2'b0, sb};
      qbit   = ~trial[17];
      acc_n  = {15'b0, qbit ? trial[16:0] : rem_sh};
      sa_n   = {16'b0, sa[14:0], qbit};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 16-bit unsigned MUL/DIV/MOD responder on the ALU ready handshake.
// Define MULDIV_EARLY_EXIT_EN to let MUL stop once the multiplier runs out of set bits.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   opsel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic [W-1:0] res,
  output logic [W-1:0] res_x,
  output logic [3:0]   flags
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      acc, sa, acc_n, sa_n;
  logic [15:0]      sb, sb_n;
  logic             op_mul, op_mod, qbit, last_iter, req_mul;
  result_t          fin, zero_res;

  muldiv_step u_step (
    .is_mul (op_mul),
    .acc    (acc),
    .sa     (sa),
    .sb     (sb),
    .acc_n  (acc_n),
    .sa_n   (sa_n),
    .sb_n   (sb_n),
    .qbit   (qbit)
  );

`ifdef MULDIV_EARLY_EXIT_EN
  assign last_iter = (cnt == 5'd15) || (op_mul && (sb_n == '0));
`else
  assign last_iter = (cnt == 5'd15);
`endif

  // No path from a/b: ready only looks at state and the op code.
  assign ready = (state == ST_DONE) || ((state == ST_IDLE) && !is_iter(opsel));

  assign req_mul  = (opsel == ALU_MUL);
  assign fin      = pack_result(op_mul, op_mod,
                                op_mul ? acc_n[15:0]  : sa_n[15:0],
                                op_mul ? acc_n[31:16] : acc_n[15:0],
                                1'b0);
  // Zero multiplier gives P=0; zero divisor gives Q=all ones, R=a.
  assign zero_res = pack_result(req_mul, opsel == ALU_MOD,
                                req_mul ? 16'h0000 : 16'hFFFF,
                                req_mul ? 16'h0000 : a,
                                !req_mul);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      sa     <= '0;
      sb     <= '0;
      op_mul <= 1'b0;
      op_mod <= 1'b0;
      res    <= '0;
      res_x  <= '0;
      flags  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_iter(opsel)) begin
            op_mul <= req_mul;
            op_mod <= (opsel == ALU_MOD);
            acc    <= '0;
            sa     <= {16'b0, a};
            sb     <= b;
            cnt    <= '0;
            if (b == '0) begin
              res   <= zero_res.res;
              res_x <= zero_res.res_x;
              flags <= zero_res.flags;
              state <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc <= acc_n;
          sa  <= sa_n;
          sb  <= sb_n;
          cnt <= cnt + 5'd1;
          if (last_iter) begin
            res   <= fin.res;
            res_x <= fin.res_x;
            flags <= fin.flags;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus random bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  opsel;
  logic [15:0] a, b;
  logic        ready;
  logic [15:0] res, res_x;
  logic [3:0]  flags;

  int passed = 0;
  int total  = 0;
  logic [15:0] last_res, last_x;

  muldiv_seq #(.W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .opsel (opsel),
    .a     (a),
    .b     (b),
    .ready (ready),
    .res   (res),
    .res_x (res_x),
    .flags (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain arithmetic on the op semantics.
  task automatic model(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv,
                       output logic [15:0] er, output logic [15:0] ex,
                       output logic [3:0] ef, output int elat);
    logic [31:0] p;
    logic [15:0] q, r;
    int msb;
    msb = 0;
    for (int i = 0; i < 16; i++) if (bv[i]) msb = i + 1;
    if (bv == 16'h0) elat = 1;
`ifdef MULDIV_EARLY_EXIT_EN
    else if (op == ALU_MUL) elat = msb + 1;
`endif
    else elat = 17;
    if (op == ALU_MUL) begin
      p  = {16'h0, av} * {16'h0, bv};
      er = p[15:0];
      ex = p[31:16];
      ef = {er == 16'h0, er[15], ex != 16'h0, ex != 16'h0};
    end else begin
      q = (bv == 16'h0) ? 16'hFFFF : av / bv;
      r = (bv == 16'h0) ? av : av % bv;
      er = (op == ALU_DIV) ? q : r;
      ex = (op == ALU_DIV) ? r : q;
      ef = {er == 16'h0, er[15], 1'b0, bv == 16'h0};
    end
  endtask

  // Called in IDLE (b2b=0) or during the previous op's DONE cycle (b2b=1).
  task automatic run_op(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv,
                        input bit b2b);
    logic [15:0] er, ex;
    logic [3:0]  ef;
    int elat, lat;
    model(op, av, bv, er, ex, ef, elat);
    opsel = op; a = av; b = bv;
    if (b2b) @(negedge clk);
    else #1;
    chk("req_ready_low", {31'b0, ready}, 32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 40);
    chk("latency", lat, elat);
    chk("res", {16'b0, res}, {16'b0, er});
    chk("res_x", {16'b0, res_x}, {16'b0, ex});
    chk("flags", {28'b0, flags}, {28'b0, ef});
    last_res = er;
    last_x   = ex;
  endtask

  // Drop to a single-cycle op and confirm no stall and that results hold.
  task automatic idle_add();
    opsel = ALU_ADD; a = 16'($urandom); b = 16'($urandom);
    @(negedge clk);
    chk("add_ready", {31'b0, ready}, 32'd1);
    chk("hold_res", {16'b0, res}, {16'b0, last_res});
    chk("hold_res_x", {16'b0, res_x}, {16'b0, last_x});
  endtask

  initial begin
    logic [4:0]  rop;
    logic [15:0] ra, rb;
    rst_n = 1'b0; opsel = ALU_ADD; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_res", {16'b0, res}, 32'd0);
    chk("rst_res_x", {16'b0, res_x}, 32'd0);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_ready_add", {31'b0, ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(ALU_MUL, 16'h1234, 16'h0010, 0); idle_add();
    run_op(ALU_DIV, 16'd100, 16'd7, 0);     idle_add();
    run_op(ALU_DIV, 16'd5, 16'd0, 0);       idle_add();
    run_op(ALU_MUL, 16'hBEEF, 16'h0000, 0); idle_add();
    run_op(ALU_MOD, 16'h1234, 16'h0000, 0); idle_add();
    run_op(ALU_MUL, 16'hFFFF, 16'hFFFF, 0); idle_add();
    run_op(ALU_MUL, 16'd3, 16'd5, 0);
    run_op(ALU_DIV, 16'd15, 16'd3, 1);      idle_add();
    run_op(ALU_MOD, 16'hFFFF, 16'h0010, 0);

    // Reset during BUSY cycle 8 of a DIV.
    opsel = ALU_DIV; a = 16'd100; b = 16'd7;
    @(negedge clk);
    repeat (8) @(negedge clk);
    chk("busy_ready_low", {31'b0, ready}, 32'd0);
    rst_n = 1'b0; opsel = ALU_ADD;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_res", {16'b0, res}, 32'd0);
    chk("midrst_res_x", {16'b0, res_x}, 32'd0);
    chk("midrst_flags", {28'b0, flags}, 32'd0);
    chk("midrst_ready_add", {31'b0, ready}, 32'd1);
    run_op(ALU_DIV, 16'd100, 16'd7, 0);     idle_add();

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0: rop = ALU_MUL;
        1: rop = ALU_DIV;
        default: rop = ALU_MOD;
      endcase
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'h0;
        1: rb = 16'($urandom_range(1, 255));
        default: rb = 16'($urandom);
      endcase
      run_op(rop, ra, rb, 0);
      idle_add();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
